// File: rtl/axi_lite_pkg.sv
// Shared types and address-decode helper for the AXI-Lite register-file responder.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Word-aligned and inside [base, base + 4*num_regs); the offset form avoids wrap at the top of the map.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input int num_regs);
    logic [31:0] span;
    span = 32'(num_regs) << 2;
    return (addr[1:0] == 2'b00) && (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage: async clear, one byte-enabled write port, one combinational read port.
module axi_lite_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite responder fronting a word-addressed register bank; independent write and read FSMs.
//   state     | meaning
//   W_IDLE    | waiting for AW and/or W
//   W_HAVE_AW | address held, waiting for W
//   W_HAVE_W  | data held, waiting for AW
//   W_COMMIT  | bank write (if decoded) and response issue at exiting edge
//   W_RESP    | bvalid held until bready
//   R_IDLE    | waiting for AR
//   R_DATA    | rvalid held until rready
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                awvalid,
  input  logic [ADDR_W-1:0]   awaddr,
  output logic                awready,
  input  logic                wvalid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                wready,
  output logic                bvalid,
  output logic [1:0]          bresp,
  input  logic                bready,
  input  logic                arvalid,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                arready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  input  logic                rready
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wr_state_t           wr_state;
  rd_state_t           rd_state;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;

  logic aw_hs, w_hs, ar_hs;
  logic aw_ok, ar_ok;
  logic bank_we;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] bank_rd_data;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign aw_ok   = addr_ok(aw_addr_q, BASE_ADDR, NUM_REGS);
  assign ar_ok   = addr_ok(araddr, BASE_ADDR, NUM_REGS);
  assign wr_idx  = IDX_W'((aw_addr_q - BASE_ADDR) >> 2);
  assign rd_idx  = IDX_W'((araddr - BASE_ADDR) >> 2);
  assign bank_we = (wr_state == W_COMMIT) && aw_ok;

  axi_lite_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rstn    (rstn),
    .we      (bank_we),
    .wr_idx  (wr_idx),
    .wr_data (w_data_q),
    .wr_strb (w_strb_q),
    .rd_idx  (rd_idx),
    .rd_data (bank_rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state  <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      // Ready is only high in accepting states, so capture can sit outside the case.
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      unique case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state <= W_COMMIT;
            awready  <= 1'b0;
            wready   <= 1'b0;
          end else if (aw_hs) begin
            wr_state <= W_HAVE_AW;
            awready  <= 1'b0;
            wready   <= 1'b1;
          end else if (w_hs) begin
            wr_state <= W_HAVE_W;
            awready  <= 1'b1;
            wready   <= 1'b0;
          end else begin
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            wr_state <= W_COMMIT;
            wready   <= 1'b0;
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            wr_state <= W_COMMIT;
            awready  <= 1'b0;
          end
        end
        W_COMMIT: begin
          wr_state <= W_RESP;
          bvalid   <= 1'b1;
          bresp    <= aw_ok ? OKAY : SLVERR;
        end
        W_RESP: begin
          if (bready) begin
            wr_state <= W_IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read data comes from the pre-edge bank contents, so a read on a commit edge sees the old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state <= R_DATA;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= ar_ok ? bank_rd_data : '0;
            rresp    <= ar_ok ? OKAY : SLVERR;
          end else begin
            arready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rd_state <= R_IDLE;
            rvalid   <= 1'b0;
            arready  <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed plus randomized bench for axi_lite_regfile_slave against an array-based register model.
module tb_axi_lite_regfile_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [16];

  axi_lite_regfile_slave dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd64);
  endfunction

  function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d,
                                           input logic [3:0] s);
    if (!mdl_addr_ok(a)) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[a/4][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"},  wready,  0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_bvalid"},  bvalid,  0);
    chk({tag, "_bresp"},   bresp,   0);
    chk({tag, "_rvalid"},  rvalid,  0);
    chk({tag, "_rdata"},   rdata,   0);
    chk({tag, "_rresp"},   rresp,   0);
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first. Entered and left at edge+1.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bhold);
    int t_aw, t_w, cyc;
    bit aw_done, w_done, aw_n, w_n;
    logic [1:0] exp_resp;
    t_aw = (lead > 0) ? lead : 0;
    t_w  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    bready = (bhold == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= t_aw);
      awaddr  = a;
      wvalid  = !w_done && (cyc >= t_w);
      wdata   = d;
      wstrb   = s;
      aw_n = awvalid && awready;
      w_n  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_n) aw_done = 1;
      if (w_n)  w_done  = 1;
      if (w_n && !aw_done) begin
        chk("w_first_wready", wready, 0);
        chk("w_first_awready", awready, 1);
      end
      if (aw_n && !w_done) chk("aw_first_awready", awready, 0);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshakes", {aw_done, w_done}, 2'b11);
    exp_resp = mdl_write(a, d, s);
    chk("b_commit_low", bvalid, 0);
    @(posedge clk); #1;
    chk("b_valid", bvalid, 1);
    chk("b_resp", bresp, exp_resp);
    for (int i = 0; i < bhold; i++) begin
      @(posedge clk); #1;
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, exp_resp);
      chk("b_hold_awready", awready, 0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("b_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int rhold);
    int cyc;
    bit done, hs;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = mdl_addr_ok(a) ? mdl[a/4] : 32'h0;
    exp_r = mdl_addr_ok(a) ? 2'b00 : 2'b10;
    arvalid = 1; araddr = a; rready = 0;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      hs = arready;
      @(posedge clk); #1;
      if (hs) done = 1;
      cyc++;
    end
    arvalid = 0;
    chk("ar_handshake", done, 1);
    chk("r_valid", rvalid, 1);
    chk("r_data", rdata, exp_d);
    chk("r_resp", rresp, exp_r);
    for (int i = 0; i < rhold; i++) begin
      @(posedge clk); #1;
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", rdata, exp_d);
      chk("r_hold_arready", arready, 0);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("r_drop", rvalid, 0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rstn = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

    #12;
    chk_all_zero("reset");
    #10;             // t=22, release between edges
    rstn = 1;
    #1;
    chk("pre_edge_awready", awready, 0);
    @(posedge clk); #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
    chk("post_rst_arready", arready, 1);

    // Directed cases
    do_write(32'h10, 32'hDEADBAAD, 4'hF, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h04, 32'h12345678, 4'hF, 3, 0);
    do_read(32'h04, 0);
    do_write(32'h08, 32'hFFFFFFFF, 4'hF, -2, 1);
    do_write(32'h08, 32'h00000000, 4'b0101, 0, 0);
    do_read(32'h08, 0);
    do_write(32'h14, 32'hCAFEF00D, 4'h0, 1, 0);
    do_write(32'h40, 32'h11111111, 4'hF, 0, 0);
    do_write(32'h11, 32'h22222222, 4'hF, -1, 0);
    do_read(32'h40, 0);
    for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0);
    do_read(32'h10, 5);
    do_write(32'h18, 32'hA1B2C3D4, 4'hF, 0, 5);

    // Randomized writes and reads
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
      else if (r == 1) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 2) == 0)
        do_read(a, $urandom_range(0, 3));
      else
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 6) - 3, $urandom_range(0, 3));
    end
    for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0);

    // Reset in the middle of a write whose W never arrives
    do_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0);
    awvalid = 1; awaddr = 32'h0C;
    @(posedge clk); #1;
    awvalid = 0;
    chk("mid_aw_taken", awready, 0);
    #2;
    rstn = 0;
    #1;
    chk_all_zero("mid_reset");
    wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    @(posedge clk); #1;
    wvalid = 0;
    rstn = 1;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    @(posedge clk); #1;
    chk("mid_rel_awready", awready, 1);
    chk("mid_rel_bvalid", bvalid, 0);
    do_read(32'h0C, 0);
    do_read(32'h10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
